// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron3 input loader.
// Holds the data width and Q8.24 format constants, the loader state encoding
// and the weight register-file addresses.
package perceptron_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned FRAC   = 24;

    // Loader sequencing: collect A/B/C, hold operands for one compute, capture result
    typedef enum logic [1:0] {
        COL   = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } loader_state_e;

    localparam logic [1:0] W_A    = 2'd0;
    localparam logic [1:0] W_B    = 2'd1;
    localparam logic [1:0] W_C    = 2'd2;
    localparam logic [1:0] W_BIAS = 2'd3;

    localparam logic [31:0] ONE = 32'h0100_0000;

endpackage

// File: rtl/perceptron_out_buf.sv
// Single-entry valid/ready holding register for the perceptron result.
// A set on the same edge as a drain wins, so a new result is never lost.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   set, set_data - load a new entry (valid goes high)
//   ready         - consumer takes the entry when valid
//   valid, data   - held entry
module perceptron_out_buf #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [DWIDTH-1:0] set_data,
    input  logic              ready,
    output logic              valid,
    output logic [DWIDTH-1:0] data
);

    logic              valid_q, valid_d;
    logic [DWIDTH-1:0] data_q,  data_d;

    // Drain first, then let a set override it
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (set) begin
            valid_d = 1'b1;
            data_d  = set_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/perceptron_input_loader.sv
// Upstream sequencer for perceptron3: assembles A, B, C from a serial
// valid/ready stream, holds weights and bias in a register file, drives all
// seven operands in parallel and captures the registered perceptron result.
// Optional: define PERC_LOADER_CNT_EN to add the sample_cnt[15:0] output,
// counting captured results (wraps at 0xFFFF).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   s_valid/s_ready/s_data    - input word stream, order A, B, C
//   w_we/w_addr/w_data/w_ack  - weight write port (0=wa 1=wb 2=wc 3=bias), ack next cycle
//   A, B, C, wa, wb, wc, bias - operands to perceptron3
//   y_in                      - perceptron3 registered output
//   y_valid/y_ready/y_data    - captured result port
module perceptron_input_loader
    import perceptron_pkg::*;
#(
    parameter int unsigned DWIDTH = perceptron_pkg::DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              w_we,
    input  logic [1:0]        w_addr,
    input  logic [DWIDTH-1:0] w_data,
    output logic              w_ack,
    output logic [DWIDTH-1:0] A,
    output logic [DWIDTH-1:0] B,
    output logic [DWIDTH-1:0] C,
    output logic [DWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wb,
    output logic [DWIDTH-1:0] wc,
    output logic [DWIDTH-1:0] bias,
`ifdef PERC_LOADER_CNT_EN
    output logic [15:0]       sample_cnt,
`endif
    input  logic [DWIDTH-1:0] y_in,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [DWIDTH-1:0] y_data
);

    loader_state_e     state_q, state_d;
    logic [1:0]        cnt_q,   cnt_d;
    logic [DWIDTH-1:0] a_q,  a_d,  b_q,  b_d,  c_q,  c_d;
    logic [DWIDTH-1:0] wa_q, wa_d, wb_q, wb_d, wc_q, wc_d, bias_q, bias_d;
    logic              w_ack_q, w_ack_d;
    logic              in_col;
    logic              capt;
    logic              word_acc;
    logic              w_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COL;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            COL: begin
                if (s_valid) begin
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = 2'(cnt_q + 2'd1);
                    end
                end
            end
            // Hold operands while the previous result is still unconsumed
            ISSUE: begin
                if (!(y_valid && !y_ready)) begin
                    state_d = CAPT;
                end
            end
            CAPT:    state_d = COL;
            default: state_d = COL;
        endcase
    end

    // State decode outputs
    always_comb begin
        in_col  = (state_q == COL);
        capt    = (state_q == CAPT);
        s_ready = in_col;
    end

    assign word_acc = s_valid && in_col;
    // Weight writes only in COL so operands never move under a computation
    assign w_acc    = w_we && in_col;

    // Operand and weight register file
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        wc_d    = wc_q;
        bias_d  = bias_q;
        w_ack_d = w_acc;
        if (word_acc) begin
            unique case (cnt_q)
                2'd0:    a_d = s_data;
                2'd1:    b_d = s_data;
                default: c_d = s_data;
            endcase
        end
        if (w_acc) begin
            unique case (w_addr)
                W_A:     wa_d   = w_data;
                W_B:     wb_d   = w_data;
                W_C:     wc_d   = w_data;
                default: bias_d = w_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            wc_q    <= '0;
            bias_q  <= '0;
            w_ack_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            wc_q    <= wc_d;
            bias_q  <= bias_d;
            w_ack_q <= w_ack_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign C     = c_q;
    assign wa    = wa_q;
    assign wb    = wb_q;
    assign wc    = wc_q;
    assign bias  = bias_q;
    assign w_ack = w_ack_q;

    // y_in is valid during CAPT; capture on the edge leaving it
    perceptron_out_buf #(
        .DWIDTH(DWIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .set     (capt),
        .set_data(y_in),
        .ready   (y_ready),
        .valid   (y_valid),
        .data    (y_data)
    );

`ifdef PERC_LOADER_CNT_EN
    logic [15:0] sample_cnt_q, sample_cnt_d;

    // Captured-result counter
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (capt) begin
            sample_cnt_d = 16'(sample_cnt_q + 16'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_q <= 16'd0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: doc/perceptron_input_loader.md
Name: perceptron_input_loader

Overview:
- Upstream sequencer for perceptron3, plus capture of its registered result.
- Accepts a serial stream of 32-bit Q8.24 inputs over a valid/ready handshake and assembles the triple A, B, C.
- Holds weights and bias in a small register file, drives all seven perceptron operands in parallel, and captures the perceptron output one cycle after issue.
- Presents the captured result on a valid/ready output port.

Parameters:
- DWIDTH, 32, data word width (signed fixed point)
- FRAC, 24, fractional bits (documentation and test only; no arithmetic here)

Ports:
- clk, in, 1, system clock, rising edge
- rst, in, 1, synchronous active-high reset
- s_valid, in, 1, input word valid
- s_ready, out, 1, loader can accept an input word
- s_data, in, DWIDTH, signed input word (order: A, then B, then C)
- w_we, in, 1, weight write strobe
- w_addr, in, 2, 0=wa, 1=wb, 2=wc, 3=bias
- w_data, in, DWIDTH, signed weight/bias value
- w_ack, out, 1, one-cycle pulse: previous-cycle write accepted
- A, B, C, out, DWIDTH each, operand registers to perceptron3
- wa, wb, wc, bias, out, DWIDTH each, weight registers to perceptron3
- y_in, in, DWIDTH, perceptron3 out (registered inside perceptron3)
- y_valid, out, 1, result valid
- y_ready, in, 1, consumer accepts result
- y_data, out, DWIDTH, captured result

Behaviour:
- Reset (synchronous, rst high at an edge): state=COL, cnt=0, all operand and weight registers=0, y_data=0, y_valid=0, w_ack=0.
- s_ready=1 only in COL. A word is accepted on an edge with s_valid && s_ready.
- COL:
  - Accepted word goes to slot cnt (0→A, 1→B, 2→C); cnt increments.
  - Acceptance at cnt==2 sets cnt=0 and moves to ISSUE.
- ISSUE:
  - A, B, C and weights are stable; perceptron3 registers sigmoid at the edge leaving this state.
  - If y_valid && !y_ready, stay in ISSUE; operands stay stable, so recomputation is harmless.
  - Otherwise go to CAPT.
- CAPT:
  - y_in is valid this cycle.
  - At the edge: y_data<=y_in, y_valid<=1, go to COL.
- y_valid clears on an edge with y_ready && y_valid, unless CAPT sets it on that same edge; set wins.
- Latency: third word accepted at edge k → y_valid=1 from cycle k+2, provided the output slot is free.
- Throughput: one result per 5 cycles with continuous s_valid and y_ready=1.
- Weight writes:
  - Accepted only in COL; wa/wb/wc/bias update at the edge, and w_ack=1 in the following cycle.
  - Writes attempted in ISSUE or CAPT are dropped and w_ack stays 0, so operands never change under an in-flight computation.
  - A write and a word accept in the same cycle are both honoured.
- Reset mid-operation: any partial triple or pending result is discarded. The perceptron3 register is reset by the same rst.
- No arithmetic is performed; values pass bit-exact.

Optional Feature:
- Macro PERC_LOADER_CNT_EN.
- Defined: extra output port sample_cnt[15:0]. It increments on every CAPT edge, wraps 0xFFFF→0, and resets to 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package perceptron_pkg holds:
  - DWIDTH/FRAC constants
  - state enum (COL, ISSUE, CAPT)
  - weight address constants (W_A=0, W_B=1, W_C=2, W_BIAS=3)
  - Q8.24 constant ONE=32'h01000000
- One sub-module, perceptron_out_buf: single-entry valid/ready holding register with set-priority; used for y_data/y_valid.

Test Plan:
- Reset, then write wa=wb=wc=0x01000000, bias=0 → w_ack pulses after each write; wa..bias read back as written; writing 0x7FFFFFFF to addr 3 sets bias=0x7FFFFFFF.
- Stream 0x00800000, 0x00400000, 0xFFC00000 with y_ready=1 → A/B/C match in ISSUE; y_valid rises 2 cycles after third accept; y_data equals the perceptron3 model output for net 0x00800000.
- Hold y_ready=0 after the first result, then send a second triple → FSM stalls in ISSUE, s_ready=0, y_data unchanged; raising y_ready delivers result 2 two cycles later.
- Issue w_we in ISSUE and CAPT → no w_ack, weights unchanged; the same write in COL is accepted.
- Assert rst after 2 of 3 words → cnt=0, A=B=0; the next three words form a fresh triple.
- With PERC_LOADER_CNT_EN, preload the counter path by running 65536 triples (or force) → sample_cnt wraps to 0.
